cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

MEM-stage coprocessor-0 and precise-exception block for the five-stage MIPS pipeline. Consumes the MEM-stage control word (CP0 write, delay-slot flag, exception flags latched through the pipeline), holds the CP0 registers BadVAddr, Count, Compare, Status, Cause and EPC, and arbitrates exceptions, interrupts and ERET. It drives a pipeline flush and the redirect PC back to the fetch stage.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, handler entry PC.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- InstValidM  in  1  MEM slot holds a real instruction, not a bubble.
- PCM  in  32  PC of the MEM-stage instruction.
- DelaySlotM  in  1  MEM instruction is in a branch/jump delay slot.
- ExcAdelFM  in  1  instruction-fetch address error.
- ExcRIM  in  1  reserved instruction.
- SyscallM  in  1  syscall.
- BreakM  in  1  break.
- ExcOvM  in  1  arithmetic overflow.
- ExcAdelM  in  1  load address error.
- ExcAdesM  in  1  store address error.
- BadAddrM  in  32  data address for load/store errors.
- EretM  in  1  ERET in MEM.
- CP0WriteM  in  1  MTC0.
- CP0WAddrM  in  5  MTC0 rd.
- CP0WDataM  in  32  MTC0 data.
- CP0RAddr  in  5  MFC0 read address.
- CP0RData  out  32  combinational read of the addressed register. Unimplemented addresses read 0.
- ExtInt  in  6  hardware interrupt lines.
- ExcFlush  out  1  flush IF/ID/EX/MEM and redirect fetch.
- ExcPC  out  32  redirect target.
- StatusOut, CauseOut, EPCOut  out  32 each  current register values.

## Operation
Register map and reset values (reset forces all of these):
- BadVAddr (8): 0.
- Count (9): 0.
- Compare (11): 0.
- Status (12): 32'h0040_0000. Writable bits are IM[15:8], EXL[1], IE[0]. BEV[22] is read-only 1.
- Cause (13): 0. BD[31] and TI[30] are read-only. IP[15:10] is hardware. IP[9:8] is software-writable. ExcCode is [6:2].
- EPC (14): 0.
- tick toggle: 0.

Count and timer:
- tick toggles every cycle. Count increments when tick=1, i.e. every second cycle, and wraps from 32'hFFFF_FFFF to 0.
- TI is set when Count==Compare with Compare≠0.
- Any write to Compare clears TI.

Interrupt sampling:
- Cause.IP[15:10] <= {ExtInt[5]|TI, ExtInt[4:0]} every cycle.
- IntPend = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- An interrupt is taken only when IntPend and InstValidM.

Priority (highest first), with ExcCode:
- Int 0x00
- AdEL fetch 0x04
- RI 0x0A
- Sys 0x08
- Bp 0x09
- Ov 0x0C
- AdEL data 0x04
- AdES 0x05

Exception flags are ignored when InstValidM=0.

On a taken exception (next edge):
- If EXL=0: EPC <= DelaySlotM ? PCM-4 : PCM, and BD <= DelaySlotM.
- If EXL=1: EPC and BD are unchanged.
- EXL <= 1. ExcCode is updated.
- BadVAddr <= PCM for a fetch AdEL, or BadAddrM for data AdEL/AdES.
- ExcFlush=1 and ExcPC=EXC_VECTOR.

ERET (no exception pending): EXL <= 0, ExcFlush=1, ExcPC=EPC.

MTC0 is applied at the next edge only if no exception is taken and ERET is not active in the same cycle.

Simultaneous events:
- Exception and MTC0: the exception wins and the write is dropped.
- MTC0 Count and increment: the write wins.
- Compare write and match: the clear wins.
- ERET and an exception flag: the exception wins.

## Timing
- ExcFlush and ExcPC are combinational from MEM-stage inputs and current state, valid in the same cycle.
- Register effects are visible on CP0RData and the *Out ports one cycle later.
- ExtInt to Cause.IP: 1 cycle. ExtInt to taking the interrupt: 2 cycles minimum, given IE=1, EXL=0, IM set and a valid instruction.
- CP0RData has no bypass of a same-cycle MTC0. Forwarding belongs to the hazard unit.
- Reset asserted mid-exception returns all state to reset values asynchronously, and ExcFlush goes to 0.
- Outputs during reset: ExcFlush=0, ExcPC=EXC_VECTOR, CP0RData reflects the reset values.

## Test plan
- Syscall in a delay slot, PCM=32'hBFC0_0104, EXL=0 -> ExcFlush=1 and ExcPC=32'hBFC0_0380. Next cycle: EPC=32'hBFC0_0100, BD=1, ExcCode=0x08, EXL=1.
- Second exception (Ov) with EXL=1 -> EPC is unchanged, ExcCode=0x0C. Then ERET -> ExcPC equals the old EPC and EXL=0.
- Store to BadAddrM=32'h8000_0003 with ExcAdesM -> BadVAddr=32'h8000_0003 and ExcCode=0x05. An MTC0 issued in the same cycle is dropped.
- Compare=10 written, Count counts from 0, Status=32'h0040_8001 -> TI=1 after 20 cycles and an interrupt is taken (ExcCode=0x00) only while InstValidM=1. Writing Compare clears TI.
- ExtInt[0]=1 with IM[10]=1 and IE=1, but a bubble in MEM -> no flush. The interrupt is taken on the next valid instruction.
- Reset pulse mid-run -> Status=32'h0040_0000, Count=0, ExcFlush=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_exception_unit_if.sv
// MEM-stage coprocessor-0 bus: pipeline control word, MFC0 read port and
// the exception redirect returned to fetch.
interface cp0_exception_unit_if;
    logic        InstValidM;
    logic [31:0] PCM;
    logic        DelaySlotM;
    logic        ExcAdelFM;
    logic        ExcRIM;
    logic        SyscallM;
    logic        BreakM;
    logic        ExcOvM;
    logic        ExcAdelM;
    logic        ExcAdesM;
    logic [31:0] BadAddrM;
    logic        EretM;
    logic        CP0WriteM;
    logic [4:0]  CP0WAddrM;
    logic [31:0] CP0WDataM;
    logic [4:0]  CP0RAddr;
    logic [31:0] CP0RData;
    logic [5:0]  ExtInt;
    logic        ExcFlush;
    logic [31:0] ExcPC;
    logic [31:0] StatusOut;
    logic [31:0] CauseOut;
    logic [31:0] EPCOut;

    modport master (
        output InstValidM, PCM, DelaySlotM, ExcAdelFM, ExcRIM, SyscallM, BreakM,
               ExcOvM, ExcAdelM, ExcAdesM, BadAddrM, EretM, CP0WriteM,
               CP0WAddrM, CP0WDataM, CP0RAddr, ExtInt,
        input  CP0RData, ExcFlush, ExcPC, StatusOut, CauseOut, EPCOut
    );

    modport slave (
        input  InstValidM, PCM, DelaySlotM, ExcAdelFM, ExcRIM, SyscallM, BreakM,
               ExcOvM, ExcAdelM, ExcAdesM, BadAddrM, EretM, CP0WriteM,
               CP0WAddrM, CP0WDataM, CP0RAddr, ExtInt,
        output CP0RData, ExcFlush, ExcPC, StatusOut, CauseOut, EPCOut
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// MEM-stage CP0 register file with precise exception/interrupt/ERET
// arbitration; drives the pipeline flush and fetch redirect.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic clk,
    input  logic rst,
    cp0_exception_unit_if.slave cp0
);

    logic        tickReg;
    logic [31:0] countReg;
    logic [31:0] compareReg;
    logic [31:0] badVAddrReg;
    logic [31:0] epcReg;
    logic [7:0]  statusImReg;
    logic        statusExlReg;
    logic        statusIeReg;
    logic        causeBdReg;
    logic        causeTiReg;
    logic [5:0]  causeIpHwReg;
    logic [1:0]  causeIpSwReg;
    logic [4:0]  causeExcCodeReg;

    logic [31:0] statusValue;
    logic [31:0] causeValue;
    logic [7:0]  pendBits;
    logic        intPend;
    logic        instValid;
    logic        excTaken;
    logic [4:0]  excCodeNext;
    logic        loadBadFetch;
    logic        loadBadData;
    logic        eretTaken;
    logic        mtc0Apply;
    logic        wrCount;
    logic        wrCompare;
    logic        wrStatus;
    logic        wrCause;
    logic        wrEpc;
    logic        timerMatch;

    assign statusValue = {9'b0, 1'b1, 6'b0, statusImReg, 6'b0, statusExlReg, statusIeReg};
    assign causeValue  = {causeBdReg, causeTiReg, 14'b0, causeIpHwReg, causeIpSwReg,
                          1'b0, causeExcCodeReg, 2'b0};

    // Per-line pending mask: IP[15:8] against IM[15:8].
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : gPend
            if (gi < 2) begin : gSw
                assign pendBits[gi] = causeIpSwReg[gi] & statusImReg[gi];
            end else begin : gHw
                assign pendBits[gi] = causeIpHwReg[gi-2] & statusImReg[gi];
            end
        end
    endgenerate

    assign intPend   = statusIeReg & ~statusExlReg & (|pendBits);
    assign instValid = cp0.InstValidM;

    // Fixed-priority exception arbitration; a bubble raises nothing.
    always_comb begin
        excTaken     = 1'b0;
        excCodeNext  = 5'h00;
        loadBadFetch = 1'b0;
        loadBadData  = 1'b0;
        if (instValid) begin
            if (intPend) begin
                excTaken = 1'b1; excCodeNext = 5'h00;
            end else if (cp0.ExcAdelFM) begin
                excTaken = 1'b1; excCodeNext = 5'h04; loadBadFetch = 1'b1;
            end else if (cp0.ExcRIM) begin
                excTaken = 1'b1; excCodeNext = 5'h0A;
            end else if (cp0.SyscallM) begin
                excTaken = 1'b1; excCodeNext = 5'h08;
            end else if (cp0.BreakM) begin
                excTaken = 1'b1; excCodeNext = 5'h09;
            end else if (cp0.ExcOvM) begin
                excTaken = 1'b1; excCodeNext = 5'h0C;
            end else if (cp0.ExcAdelM) begin
                excTaken = 1'b1; excCodeNext = 5'h04; loadBadData = 1'b1;
            end else if (cp0.ExcAdesM) begin
                excTaken = 1'b1; excCodeNext = 5'h05; loadBadData = 1'b1;
            end
        end
    end

    assign eretTaken  = instValid & cp0.EretM & ~excTaken;
    assign mtc0Apply  = instValid & cp0.CP0WriteM & ~excTaken & ~eretTaken;
    assign wrCount    = mtc0Apply && (cp0.CP0WAddrM == 5'd9);
    assign wrCompare  = mtc0Apply && (cp0.CP0WAddrM == 5'd11);
    assign wrStatus   = mtc0Apply && (cp0.CP0WAddrM == 5'd12);
    assign wrCause    = mtc0Apply && (cp0.CP0WAddrM == 5'd13);
    assign wrEpc      = mtc0Apply && (cp0.CP0WAddrM == 5'd14);
    assign timerMatch = (countReg == compareReg) && (compareReg != 32'd0);

    // Reset masks the redirect so a held-in-reset pipeline is never flushed.
    assign cp0.ExcFlush  = rst & (excTaken | eretTaken);
    assign cp0.ExcPC     = (rst & eretTaken) ? epcReg : EXC_VECTOR;
    assign cp0.StatusOut = statusValue;
    assign cp0.CauseOut  = causeValue;
    assign cp0.EPCOut    = epcReg;

    always_comb begin
        case (cp0.CP0RAddr)
            5'd8:    cp0.CP0RData = badVAddrReg;
            5'd9:    cp0.CP0RData = countReg;
            5'd11:   cp0.CP0RData = compareReg;
            5'd12:   cp0.CP0RData = statusValue;
            5'd13:   cp0.CP0RData = causeValue;
            5'd14:   cp0.CP0RData = epcReg;
            default: cp0.CP0RData = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tickReg         <= 1'b0;
            countReg        <= 32'd0;
            compareReg      <= 32'd0;
            badVAddrReg     <= 32'd0;
            epcReg          <= 32'd0;
            statusImReg     <= 8'd0;
            statusExlReg    <= 1'b0;
            statusIeReg     <= 1'b0;
            causeBdReg      <= 1'b0;
            causeTiReg      <= 1'b0;
            causeIpHwReg    <= 6'd0;
            causeIpSwReg    <= 2'd0;
            causeExcCodeReg <= 5'd0;
        end else begin
            tickReg      <= ~tickReg;
            causeIpHwReg <= {cp0.ExtInt[5] | causeTiReg, cp0.ExtInt[4:0]};

            if (wrCount)      countReg <= cp0.CP0WDataM;
            else if (tickReg) countReg <= countReg + 32'd1;

            if (wrCompare) compareReg <= cp0.CP0WDataM;

            // A Compare write acknowledges the timer even on a match cycle.
            if (wrCompare)       causeTiReg <= 1'b0;
            else if (timerMatch) causeTiReg <= 1'b1;

            if (excTaken) begin
                statusExlReg    <= 1'b1;
                causeExcCodeReg <= excCodeNext;
                // Nested exceptions keep the original return point.
                if (!statusExlReg) begin
                    epcReg     <= cp0.DelaySlotM ? (cp0.PCM - 32'd4) : cp0.PCM;
                    causeBdReg <= cp0.DelaySlotM;
                end
                if (loadBadFetch)     badVAddrReg <= cp0.PCM;
                else if (loadBadData) badVAddrReg <= cp0.BadAddrM;
            end else if (eretTaken) begin
                statusExlReg <= 1'b0;
            end else begin
                if (wrStatus) begin
                    statusImReg  <= cp0.CP0WDataM[15:8];
                    statusExlReg <= cp0.CP0WDataM[1];
                    statusIeReg  <= cp0.CP0WDataM[0];
                end
                if (wrCause) causeIpSwReg <= cp0.CP0WDataM[9:8];
                if (wrEpc)   epcReg       <= cp0.CP0WDataM;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed scoreboard bench: stimulus queues expectations, a negedge monitor
// pops and compares them against the CP0 outputs.
module tb_cp0_exception_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct {
        string       name;
        int          kind;   // 0 CP0RData, 1 flush, 2 Status, 3 Cause, 4 EPC
        logic [31:0] exp;
        logic        expFlush;
    } chk_t;

    logic clk;
    logic rst;
    cp0_exception_unit_if bus();

    cp0_exception_unit #(.EXC_VECTOR(VEC)) dut (
        .clk (clk),
        .rst (rst),
        .cp0 (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    chk_t scoreQ[$];
    int   checks = 0;
    int   passed = 0;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    chk_t monEntry;
    bit   sawFlush;
    always @(negedge clk) begin
        sawFlush = 1'b0;
        while (scoreQ.size() > 0) begin
            monEntry = scoreQ.pop_front();
            case (monEntry.kind)
                0: compare(monEntry.name, bus.CP0RData, monEntry.exp);
                1: begin
                    sawFlush = 1'b1;
                    compare({monEntry.name, ".flush"}, {31'b0, bus.ExcFlush}, {31'b0, monEntry.expFlush});
                    compare({monEntry.name, ".pc"}, bus.ExcPC, monEntry.exp);
                end
                2: compare(monEntry.name, bus.StatusOut, monEntry.exp);
                3: compare(monEntry.name, bus.CauseOut, monEntry.exp);
                default: compare(monEntry.name, bus.EPCOut, monEntry.exp);
            endcase
        end
        if (!sawFlush && bus.ExcFlush === 1'b1) begin
            checks++;
            $display("FAIL unexpected_flush: got ExcFlush=1 pc=%h, expected 0", bus.ExcPC);
        end
    end

    task automatic clrIn();
        bus.InstValidM = 0; bus.PCM = 0; bus.DelaySlotM = 0;
        bus.ExcAdelFM = 0; bus.ExcRIM = 0; bus.SyscallM = 0; bus.BreakM = 0;
        bus.ExcOvM = 0; bus.ExcAdelM = 0; bus.ExcAdesM = 0; bus.BadAddrM = 0;
        bus.EretM = 0; bus.CP0WriteM = 0; bus.CP0WAddrM = 0; bus.CP0WDataM = 0;
        bus.CP0RAddr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clrIn();
    endtask

    task automatic txn(input string s);
        $display("txn t=%0t %s", $time, s);
    endtask

    task automatic expFlush(input string n, input logic f, input logic [31:0] pc);
        chk_t e; e.name = n; e.kind = 1; e.exp = pc; e.expFlush = f;
        scoreQ.push_back(e);
    endtask

    task automatic expReg(input string n, input logic [4:0] a, input logic [31:0] v);
        chk_t e; e.name = n; e.kind = 0; e.exp = v; e.expFlush = 0;
        bus.CP0RAddr = a;
        scoreQ.push_back(e);
    endtask

    task automatic expOut(input string n, input int k, input logic [31:0] v);
        chk_t e; e.name = n; e.kind = k; e.exp = v; e.expFlush = 0;
        scoreQ.push_back(e);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.InstValidM = 1; bus.CP0WriteM = 1; bus.CP0WAddrM = a; bus.CP0WDataM = d;
    endtask

    task automatic eret(input string n, input logic [31:0] pc);
        txn({"eret ", n});
        bus.InstValidM = 1; bus.EretM = 1;
        expFlush(n, 1'b1, pc);
    endtask

    initial begin
        rst = 1'b0;
        bus.ExtInt = 6'd0;
        clrIn();
        step();

        // During reset: syscall must not flush, registers at reset values
        txn("reset hold");
        bus.InstValidM = 1; bus.SyscallM = 1;
        expFlush("rst_noflush", 1'b0, VEC);
        expReg("rst_status", 5'd12, 32'h0040_0000);
        expOut("rst_cause", 3, 32'h0);
        step();
        rst = 1'b1;

        txn("syscall in delay slot");
        bus.InstValidM = 1; bus.SyscallM = 1; bus.DelaySlotM = 1; bus.PCM = 32'hBFC0_0104;
        expFlush("sys_ds", 1'b1, VEC);
        step();
        expReg("sys_epc", 5'd14, 32'hBFC0_0100);
        expOut("sys_status", 2, 32'h0040_0002);
        expOut("sys_cause", 3, 32'h8000_0020);
        step();

        txn("overflow with EXL=1");
        bus.InstValidM = 1; bus.ExcOvM = 1; bus.PCM = 32'h8000_1000;
        expFlush("ov_nested", 1'b1, VEC);
        step();
        expReg("ov_cause", 5'd13, 32'h8000_0030);
        expOut("ov_epc_kept", 4, 32'hBFC0_0100);
        step();

        txn("eret with syscall");
        bus.InstValidM = 1; bus.EretM = 1; bus.SyscallM = 1; bus.PCM = 32'h8000_1004;
        expFlush("eret_vs_exc", 1'b1, VEC);
        step();
        expOut("eret_vs_exc_cause", 3, 32'h8000_0020);
        expOut("eret_vs_exc_status", 2, 32'h0040_0002);
        step();

        eret("eret1", 32'hBFC0_0100);
        step();
        expReg("eret1_status", 5'd12, 32'h0040_0000);
        step();

        txn("store AdES with MTC0 EPC");
        bus.InstValidM = 1; bus.ExcAdesM = 1; bus.BadAddrM = 32'h8000_0003; bus.PCM = 32'h8000_2000;
        bus.CP0WriteM = 1; bus.CP0WAddrM = 5'd14; bus.CP0WDataM = 32'h1234_5678;
        expFlush("ades", 1'b1, VEC);
        step();
        expReg("ades_badv", 5'd8, 32'h8000_0003);
        expOut("ades_epc_nowrite", 4, 32'h8000_2000);
        expOut("ades_cause", 3, 32'h0000_0014);
        step();
        eret("eret2", 32'h8000_2000);
        step();

        txn("fetch AdEL + RI + data AdEL");
        bus.InstValidM = 1; bus.ExcAdelFM = 1; bus.ExcRIM = 1; bus.ExcAdelM = 1;
        bus.PCM = 32'h8000_3001; bus.BadAddrM = 32'hDEAD_0000;
        expFlush("adelf", 1'b1, VEC);
        step();
        expReg("adelf_badv", 5'd8, 32'h8000_3001);
        expOut("adelf_cause", 3, 32'h0000_0010);
        step();

        txn("RI + syscall + break");
        bus.InstValidM = 1; bus.ExcRIM = 1; bus.SyscallM = 1; bus.BreakM = 1; bus.PCM = 32'h8000_3100;
        expFlush("ri", 1'b1, VEC);
        step();
        expReg("ri_badv_kept", 5'd8, 32'h8000_3001);
        expOut("ri_cause", 3, 32'h0000_0028);
        step();
        eret("eret3", 32'h8000_3001);
        step();

        txn("mtc0 status masked");
        mtc0(5'd12, 32'hFFFF_8001);
        expFlush("mtc0_status", 1'b0, VEC);
        step();
        expReg("status_mask", 5'd12, 32'h0040_8001);
        step();
        txn("mtc0 cause");
        mtc0(5'd13, 32'hFFFF_FFFF);
        step();
        expReg("cause_mask", 5'd13, 32'h0000_0328);
        step();
        mtc0(5'd13, 32'h0);
        step();

        // Asynchronous reset pulse: checked before any clock edge passes
        txn("reset pulse");
        rst = 1'b0;
        bus.InstValidM = 1; bus.SyscallM = 1;
        expFlush("pulse_noflush", 1'b0, VEC);
        expReg("pulse_count", 5'd9, 32'h0);
        expOut("pulse_status", 2, 32'h0040_0000);
        expOut("pulse_epc", 4, 32'h0);
        step();
        rst = 1'b1;

        txn("timer setup");
        mtc0(5'd11, 32'd10);
        step();                      // E1
        mtc0(5'd12, 32'h0040_8001);
        step();                      // E2
        for (int i = 0; i < 18; i++) step();   // through E20
        expReg("count10", 5'd9, 32'd10);
        expOut("ti_not_yet", 3, 32'h0);
        step();                      // E21
        expOut("ti_set", 3, 32'h4000_0000);
        step();                      // E22
        expOut("ip7_set", 3, 32'h4000_8000);
        expFlush("timer_bubble", 1'b0, VEC);
        step();                      // E23
        txn("timer interrupt on valid instruction");
        bus.InstValidM = 1; bus.PCM = 32'h8000_4000;
        expFlush("timer_int", 1'b1, VEC);
        step();                      // E24
        txn("compare write clears TI");
        mtc0(5'd11, 32'd1000);
        expOut("tint_cause", 3, 32'h4000_8000);
        expOut("tint_status", 2, 32'h0040_8003);
        expOut("tint_epc", 4, 32'h8000_4000);
        step();
        expOut("ti_cleared", 3, 32'h0000_8000);
        step();
        expOut("ip7_cleared", 3, 32'h0);
        step();

        eret("eret4", 32'h8000_4000);
        step();
        txn("mtc0 status IM[10]");
        mtc0(5'd12, 32'h0000_0401);
        step();

        txn("extint with bubble");
        bus.ExtInt = 6'b000001;
        step();
        expFlush("ext_bubble", 1'b0, VEC);
        expOut("ext_cause", 3, 32'h0000_0400);
        step();
        txn("extint taken");
        bus.InstValidM = 1; bus.PCM = 32'h8000_5000;
        expFlush("ext_int", 1'b1, VEC);
        step();
        bus.ExtInt = 6'd0;
        expOut("ext_epc", 4, 32'h8000_5000);
        expOut("ext_status", 2, 32'h0040_0403);
        expOut("ext_cause_code", 3, 32'h0000_0400);
        step();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
